instr_exec_sequencer: RTL and testbench

Sequences execution of the 32-entry instruction register. After a start command it walks read_pointer from a start address over N entries with wrap-around. For each entry it captures the instruction_word, evaluates it on an internal ALU, and offers a 64-bit signed result downstream on a valid/ready handshake. It sits between the instruction register's read port and the result checker/scoreboard.

---
 rtl/instr_exec_sequencer_pkg.sv | 38 +++
 rtl/instr_exec_sequencer_alu.sv | 43 ++++
 rtl/instr_exec_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_exec_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_exec_sequencer_pkg.sv
// Shared instruction-register types: addresses, opcodes, instruction word, result and sequencer state.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package instr_exec_sequencer_pkg;

    localparam int ADDR_W             = 5;
    localparam int DIV_CYCLES_DEFAULT = 4;

    typedef logic [ADDR_W-1:0] address_t;

    // Values 8..15 are representable in the field but are illegal opcodes.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t            opc;
        logic signed [31:0] op_a;
        logic signed [31:0] op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUTPUT, DONE} seq_state_t;

    // Opcodes that occupy the divider for more than one EXEC cycle.
    function automatic logic is_long_op(input opcode_t opc);
        return (opc == DIV) || (opc == MOD);
    endfunction

endpackage

// File: rtl/instr_exec_sequencer_alu.sv
// Combinational ALU: evaluates one instruction word into a 64-bit signed result plus flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the sequencer decides when the output is sampled.
module instr_alu
    import instr_exec_sequencer_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_by_zero,
    output logic         illegal_opc
);

    result_t op_a;
    result_t op_b;

    assign op_a = {{32{instr.op_a[31]}}, instr.op_a};
    assign op_b = {{32{instr.op_b[31]}}, instr.op_b};

    // Opcode decode; a zero divisor or an unknown opcode forces a zero result.
    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        illegal_opc = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = op_a;
            PASSB: result = op_b;
            ADD:   result = op_a + op_b;
            SUB:   result = op_a - op_b;
            MULT:  result = op_a * op_b;
            DIV: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result      = op_a / op_b;
            end
            MOD: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result      = op_a % op_b;
            end
            default: illegal_opc = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks the instruction register from start_addr over count entries, executes each and offers the result.
// Latency: start -> first result_valid is 3 cycles, plus DIV_CYCLES-1 for DIV/MOD entries.
// Backpressure: result held stable in OUTPUT until result_ready; abort is the only way to drop it early.
module instr_exec_sequencer
    import instr_exec_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   count,
    input  logic         abort,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         result_valid,
    input  logic         result_ready,
    output result_t      result,
    output address_t     result_addr,
    output opcode_t      result_opc,
    output logic         div_by_zero,
    output logic         illegal_opc,
    output logic         busy,
    output logic         done
);

    localparam int DCW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    seq_state_t   state;
    address_t     cur_addr;
    logic [5:0]   remaining;
    logic [5:0]   count_clamped;
    instruction_t instr_q;
    logic [DCW-1:0] div_cnt;

    result_t alu_result;
    logic    alu_div_by_zero;
    logic    alu_illegal_opc;

    // Requests beyond the register depth execute each entry once.
    assign count_clamped = (count > 6'(NUM_ENTRIES)) ? 6'(NUM_ENTRIES) : count;

    instr_alu u_alu (
        .instr       (instr_q),
        .result      (alu_result),
        .div_by_zero (alu_div_by_zero),
        .illegal_opc (alu_illegal_opc)
    );

    // Sequencer FSM with registered outputs, address/remaining counters and divider latency counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            instr_q      <= '0;
            div_cnt      <= '0;
            read_pointer <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_addr  <= '0;
            result_opc   <= ZERO;
            div_by_zero  <= 1'b0;
            illegal_opc  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Abandon the sequence; result outputs other than valid keep their values.
                state        <= IDLE;
                result_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            busy <= 1'b1;
                            if (count_clamped == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                cur_addr     <= start_addr;
                                remaining    <= count_clamped;
                                read_pointer <= start_addr;
                                state        <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        instr_q <= instruction_word;
                        div_cnt <= DCW'(DIV_CYCLES - 1);
                        state   <= EXEC;
                    end
                    EXEC: begin
                        if (is_long_op(instr_q.opc) && (div_cnt != '0)) begin
                            div_cnt <= div_cnt - DCW'(1);
                        end else begin
                            result       <= alu_result;
                            result_addr  <= cur_addr;
                            result_opc   <= instr_q.opc;
                            div_by_zero  <= alu_div_by_zero;
                            illegal_opc  <= alu_illegal_opc;
                            result_valid <= 1'b1;
                            state        <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (result_ready) begin
                            result_valid <= 1'b0;
                            cur_addr     <= cur_addr + 5'd1;
                            remaining    <= remaining - 6'd1;
                            if (remaining == 6'd1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                read_pointer <= cur_addr + 5'd1;
                                state        <= FETCH;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Bench for instr_exec_sequencer: directed scenarios plus randomized sequences against a behavioural model.
// Expected results come from an arithmetic model of the opcode rules and the stated cycle timing.
// Drives inputs #1 after each rising edge and samples outputs at the same point.
module tb_instr_exec_sequencer;
    import instr_exec_sequencer_pkg::*;

    localparam int DIVC = DIV_CYCLES_DEFAULT;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_addr;
    logic [5:0]   count;
    logic         abort;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         result_valid;
    logic         result_ready;
    result_t      result;
    address_t     result_addr;
    opcode_t      result_opc;
    logic         div_by_zero;
    logic         illegal_opc;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int total = 0;
    int bad   = 0;

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_exec_sequencer #(.NUM_ENTRIES(32), .DIV_CYCLES(DIVC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .abort            (abort),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_addr      (result_addr),
        .result_opc       (result_opc),
        .div_by_zero      (div_by_zero),
        .illegal_opc      (illegal_opc),
        .busy             (busy),
        .done             (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instruction_t mk(input logic [3:0] opc, input int a, input int b);
        instruction_t r;
        r.opc  = opcode_t'(opc);
        r.op_a = a;
        r.op_b = b;
        return r;
    endfunction

    // Reference arithmetic: division built from magnitudes, remainder from dividend - quotient*divisor.
    function automatic void model(input instruction_t ins, output longint r,
                                  output logic dz, output logic il);
        longint a, b, q;
        int op;
        a  = ins.op_a;
        b  = ins.op_b;
        op = int'(ins.opc);
        r  = 0;
        dz = 1'b0;
        il = 1'b0;
        if (op > 7)       il = 1'b1;
        else if (op == 0) r = 0;
        else if (op == 1) r = a;
        else if (op == 2) r = b;
        else if (op == 3) r = a + b;
        else if (op == 4) r = a - b;
        else if (op == 5) r = a * b;
        else if (b == 0)  dz = 1'b1;
        else begin
            q = ((a < 0) ? -a : a) / ((b < 0) ? -b : b);
            if ((a < 0) != (b < 0)) q = -q;
            r = (op == 6) ? q : (a - q * b);
        end
    endfunction

    function automatic int exec_len(input instruction_t ins);
        return (int'(ins.opc) == 6 || int'(ins.opc) == 7) ? DIVC : 1;
    endfunction

    // rmode: 0 = always ready, 1 = random ready, 2 = stall first result for 5 valid cycles.
    task automatic run_seq(input address_t sa, input int cnt, input int rmode, input bit extra_start);
        int n, got, dones, done_c, last_hs, stall, elen;
        bit seen, vld_ever;
        longint er;
        logic edz, eil;
        address_t ea;
        logic [3:0] eo;
        n = (cnt > 32) ? 32 : cnt;
        got = 0; dones = 0; done_c = 0; last_hs = 0; stall = 0; elen = 1;
        seen = 0; vld_ever = 0; er = 0; edz = 0; eil = 0; ea = '0; eo = '0;
        start_addr   = sa;
        count        = 6'(cnt);
        start        = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if (c == 1) chk("busy_after_start", busy, 1);
            if (done) begin
                dones++;
                if (dones == 1) done_c = c;
            end
            if (extra_start && done) begin
                start = 1'b1; count = 6'd3;
            end else if (extra_start && c == 4) begin
                start = 1'b1; count = 6'd3; start_addr = sa + 5'd1;
            end else begin
                start = 1'b0;
            end
            if (result_valid) begin
                vld_ever = 1;
                if (!seen) begin
                    ea = sa + address_t'(got);
                    model(mem[ea], er, edz, eil);
                    eo   = mem[ea].opc;
                    elen = exec_len(mem[ea]);
                    chk("valid_latency", c, last_hs + 2 + elen);
                    seen = 1;
                end
                chk("result", result, er);
                chk("result_addr", result_addr, ea);
                chk("result_opc", result_opc, eo);
                chk("div_by_zero", div_by_zero, edz);
                chk("illegal_opc", illegal_opc, eil);
                case (rmode)
                    0: result_ready = 1'b1;
                    1: result_ready = 1'($urandom_range(0, 1));
                    default: begin
                        result_ready = (got > 0) || (stall >= 5);
                        if (!result_ready) stall++;
                    end
                endcase
                if (result_ready) begin
                    got++;
                    last_hs = c;
                    seen = 0;
                end
            end else begin
                result_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (dones > 0 && c > done_c) begin
                chk("busy_after_done", busy, 0);
                chk("valid_after_done", result_valid, 0);
            end
            if (dones > 0 && c >= done_c + 2) break;
            tick();
        end
        start = 1'b0;
        result_ready = 1'b1;
        chk("n_results", got, n);
        chk("done_pulses", dones, 1);
        if (n == 0) begin
            chk("valid_never", vld_ever, 0);
            chk("zero_done_by_2", (done_c >= 1 && done_c <= 2), 1);
        end else begin
            chk("done_cycle", done_c, last_hs + 1);
            chk("result_hold_after_done", result, er);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            int a, b;
            a = ($urandom_range(0, 1) == 1) ? int'($urandom) : (int'($urandom_range(0, 20)) - 10);
            b = ($urandom_range(0, 3) == 0) ? 0 :
                (($urandom_range(0, 1) == 1) ? int'($urandom) : (int'($urandom_range(0, 20)) - 10));
            mem[i] = mk(4'($urandom_range(0, 15)), a, b);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_read_pointer"}, read_pointer, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_addr"}, result_addr, 0);
        chk({tag, "_result_opc"}, result_opc, 0);
        chk({tag, "_div_by_zero"}, div_by_zero, 0);
        chk({tag, "_illegal_opc"}, illegal_opc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        bit saw;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b1;
        start_addr = '0; count = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        tick(); tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Basic arithmetic run with ignored start pulses while busy.
        mem[0] = mk(4'd3, 5, 7);
        mem[1] = mk(4'd4, 3, 10);
        mem[2] = mk(4'd5, -4, 6);
        mem[3] = mk(4'd2, 0, -9);
        run_seq(5'd0, 4, 0, 1'b1);

        // Wrap-around with multi-cycle DIV/MOD.
        mem[30] = mk(4'd5, 32'h7FFFFFFF, 2);
        mem[31] = mk(4'd6, -7, 2);
        mem[0]  = mk(4'd7, -7, 2);
        run_seq(5'd30, 3, 0, 1'b0);

        // Divide by zero and illegal opcode.
        mem[5] = mk(4'd6, 9, 0);
        mem[6] = mk(4'hC, 1, 2);
        run_seq(5'd5, 2, 0, 1'b0);

        // Backpressure on the first result.
        mem[0] = mk(4'd3, 5, 7);
        run_seq(5'd0, 4, 2, 1'b0);

        // Zero-length sequence.
        run_seq(5'd3, 0, 0, 1'b0);

        // Abort while executing a DIV.
        mem[10] = mk(4'd6, 100, 7);
        start_addr = 5'd10; count = 6'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("abort_rp_hold", read_pointer, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || result_valid || busy) saw = 1;
        end
        chk("abort_quiet", saw, 0);

        // Abort wins over start in IDLE.
        start_addr = 5'd0; count = 6'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", busy, 0);

        // Reset asserted while a result is offered.
        result_ready = 1'b0;
        start_addr = 5'd0; count = 6'd4; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("pre_reset_valid", result_valid, 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        reset_n = 1'b1;
        result_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) saw = 1;
        end
        chk("post_reset_quiet", saw, 0);
        run_seq(5'd0, 4, 0, 1'b0);

        // Count clamp and randomized sequences.
        fill_random();
        run_seq(5'd7, 45, 0, 1'b0);
        for (int it = 0; it < 3; it++) begin
            fill_random();
            run_seq(address_t'($urandom_range(0, 31)), int'($urandom_range(1, 40)), 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
